// File: rtl/ram_master_pkg.sv
// Shared types and constants for the RAM burst master and its read-side FIFO.
package ram_master_pkg;
    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    localparam int RD_FIFO_DEPTH = 4;
    localparam int RD_PTR_W      = $clog2(RD_FIFO_DEPTH);
endpackage

// File: rtl/ram_rd_fifo.sv
// Small synchronous FIFO buffering RAM read data against downstream backpressure.
module ram_rd_fifo
    import ram_master_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [RD_PTR_W:0]     count,
    output logic                  empty
);
    localparam int CW = RD_PTR_W + 1;

    logic [DATA_WIDTH-1:0] mem [RD_FIFO_DEPTH];
    logic [RD_PTR_W-1:0]   wr_ptr, rd_ptr;

    // Depth is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < RD_FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + RD_PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + RD_PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign empty = (count == '0);
endmodule

// File: rtl/ram_burst_master.sv
// Burst initiator for a single-port registered-read RAM: one RAM access per beat,
// with credit-based read issue so the output FIFO can never overflow.
module ram_burst_master
    import ram_master_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  busy,
    output logic                  done
);
    // One extra bit so a full 2^LEN_WIDTH-beat burst fits.
    localparam int CNT_W = LEN_WIDTH + 1;
    localparam int INF_W = RD_PTR_W + 2;

    state_t                state, next_state;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [CNT_W-1:0]      beats, issue_left;
    logic                  f1, f2;
    logic [RD_PTR_W:0]     fifo_count;
    logic                  fifo_empty;
    logic                  cmd_fire, wr_fire, pop, issue, last_beat;
    logic [INF_W-1:0]      inflight;

    assign cmd_fire  = (state == IDLE) && cmd_valid;
    assign wr_fire   = (state == WRITE) && wr_valid;
    assign pop       = (state == READ) && !fifo_empty && rd_ready;
    // Credits count buffered beats plus both RAM pipeline stages.
    assign inflight  = INF_W'(fifo_count) + INF_W'(f1) + INF_W'(f2);
    assign issue     = (state == READ) && (issue_left != '0) &&
                       (inflight < INF_W'(RD_FIFO_DEPTH));
    assign last_beat = (beats == CNT_W'(1));
    assign busy      = (state != IDLE);
    assign rd_valid  = !fifo_empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        cmd_ready  = 1'b0;
        wr_ready   = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) next_state = cmd_write ? WRITE : READ;
            end
            WRITE: begin
                wr_ready = 1'b1;
                if (wr_valid && last_beat) next_state = IDLE;
            end
            READ:    if (pop && last_beat) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_addr   <= '0;
            beats      <= '0;
            issue_left <= '0;
            f1         <= 1'b0;
            f2         <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            ram_we     <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            f1   <= issue;
            f2   <= f1;
            if (cmd_fire) begin
                cur_addr   <= cmd_addr;
                beats      <= CNT_W'(cmd_len) + CNT_W'(1);
                issue_left <= cmd_write ? '0 : CNT_W'(cmd_len) + CNT_W'(1);
            end
            if (wr_fire) begin
                ram_addr  <= cur_addr;
                ram_wdata <= wr_data;
                ram_we    <= 1'b1;
                cur_addr  <= cur_addr + ADDR_WIDTH'(1);
                beats     <= beats - CNT_W'(1);
                if (last_beat) done <= 1'b1;
            end else begin
                ram_we <= 1'b0;
            end
            if (issue) begin
                ram_addr   <= cur_addr;
                cur_addr   <= cur_addr + ADDR_WIDTH'(1);
                issue_left <= issue_left - CNT_W'(1);
            end
            if (pop) begin
                beats <= beats - CNT_W'(1);
                if (last_beat) done <= 1'b1;
            end
        end
    end

    ram_rd_fifo #(.DATA_WIDTH(DATA_WIDTH)) u_rd_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (f2),
        .pop   (pop),
        .din   (ram_rdata),
        .dout  (rd_data),
        .count (fifo_count),
        .empty (fifo_empty)
    );
endmodule

// File: tb/tb_ram_burst_master.sv
// Directed bench for ram_burst_master with an attached RAM model and expected-beat queues.
module tb_ram_burst_master;
    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic        wr_valid, wr_ready;
    logic [7:0]  wr_data;
    logic        rd_valid, rd_ready;
    logic [7:0]  rd_data;
    logic [31:0] ram_addr;
    logic [7:0]  ram_wdata, ram_rdata;
    logic        ram_we, busy, done;

    int n_assert = 0;
    int n_fail   = 0;
    int done_seen = 0;

    logic [7:0]  mem   [256];
    logic [7:0]  model [256];
    bit          ram_inited = 1'b0;

    typedef struct packed { logic [31:0] addr; logic [7:0] data; } wbeat_t;
    wbeat_t      wq[$];
    logic [7:0]  rq[$];

    ram_burst_master dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
        .ram_rdata(ram_rdata), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Registered-read single-port RAM, preloaded once with addr ^ 0x5A.
    always @(posedge clk) begin
        if (!ram_inited) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
            ram_rdata  <= '0;
            ram_inited <= 1'b1;
        end else begin
            if (ram_we) mem[ram_addr[7:0]] <= ram_wdata;
            ram_rdata <= mem[ram_addr[7:0]];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Read beats are scored just before the edge that consumes them; writes just after.
    task automatic tick();
        logic [7:0] e;
        wbeat_t     w;
        if (rd_valid === 1'b1 && rd_ready === 1'b1) begin
            n_assert++;
            assert (rq.size() > 0) else begin
                n_fail++;
                $error("FAIL rd_extra: got %0h expected no beat", rd_data);
            end
            if (rq.size() > 0) begin
                e = rq.pop_front();
                check("rd_data", 32'(rd_data), 32'(e));
            end
        end
        @(posedge clk);
        @(negedge clk);
        if (done === 1'b1) done_seen++;
        if (ram_we === 1'b1) begin
            n_assert++;
            assert (wq.size() > 0) else begin
                n_fail++;
                $error("FAIL we_extra: got addr %0h expected no write", ram_addr);
            end
            if (wq.size() > 0) begin
                w = wq.pop_front();
                check("ram_addr_wr", ram_addr, w.addr);
                check("ram_wdata", 32'(ram_wdata), 32'(w.data));
            end
        end
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while (rq.size() > 0 && k < budget) begin
            tick();
            k++;
        end
        check("drain_left", 32'(rq.size()), 32'd0);
    endtask

    task automatic send_cmd(input logic wr, input logic [31:0] a, input logic [7:0] l);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = l;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        int          n;
        int          d0;
        logic [31:0] a;
        reset = 1'b0; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0;
        wr_valid = 0; wr_data = '0; rd_ready = 0;
        for (int i = 0; i < 256; i++) model[i] = 8'(i) ^ 8'h5A;
        @(negedge clk); @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_wr_ready",  32'(wr_ready),  32'd0);
        check("rst_rd_valid",  32'(rd_valid),  32'd0);
        check("rst_rd_data",   32'(rd_data),   32'd0);
        check("rst_ram_addr",  ram_addr,       32'd0);
        check("rst_ram_wdata", 32'(ram_wdata), 32'd0);
        check("rst_ram_we",    32'(ram_we),    32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_done",      32'(done),      32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Write burst 0x10..0x13 with wr_valid held high
        wr_valid = 1'b1; wr_data = 8'hA1;
        send_cmd(1'b1, 32'h10, 8'd3);
        check("wr_we_after_cmd", 32'(ram_we), 32'd0);
        for (int i = 0; i < 4; i++) begin
            wr_data = 8'hA1 + 8'(i);
            wq.push_back('{addr: 32'h10 + 32'(i), data: wr_data});
            model[8'h10 + 8'(i)] = wr_data;
            tick();
            check("wr_we", 32'(ram_we), 32'd1);
            check("wr_done", 32'(done), (i == 3) ? 32'd1 : 32'd0);
        end
        check("wr_busy_after", 32'(busy), 32'd0);
        wr_valid = 1'b0;
        tick();
        check("wr_we_idle", 32'(ram_we), 32'd0);
        check("wr_q_empty", 32'(wq.size()), 32'd0);

        // Read back with rd_ready held: latency 3, then one beat per cycle
        rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) rq.push_back(8'hA1 + 8'(i));
        send_cmd(1'b0, 32'h10, 8'd3);
        n = 0;
        while (rd_valid !== 1'b1 && n < 20) begin tick(); n++; end
        check("rd_latency", 32'(n), 32'd3);
        for (int i = 0; i < 4; i++) begin
            check("rd_no_bubble", 32'(rd_valid), 32'd1);
            tick();
        end
        check("rd_q_empty", 32'(rq.size()), 32'd0);
        check("rd_done", 32'(done), 32'd1);
        check("rd_busy_after", 32'(busy), 32'd0);

        // Backpressure: 8-beat read, consumer stalled for 10 cycles
        rd_ready = 1'b0;
        for (int i = 0; i < 8; i++) rq.push_back(model[8'h20 + 8'(i)]);
        send_cmd(1'b0, 32'h20, 8'd7);
        for (int i = 0; i < 10; i++) tick();
        check("bp_issue_stall", ram_addr, 32'h23);
        check("bp_rd_valid", 32'(rd_valid), 32'd1);
        d0 = done_seen;
        rd_ready = 1'b1;
        drain(40);
        check("bp_done", 32'(done), 32'd1);
        check("bp_done_count", 32'(done_seen - d0), 32'd1);

        // Address wrap at the top of the address space
        a = 32'hFFFF_FFFE;
        for (int i = 0; i < 4; i++) rq.push_back(model[8'(a + 32'(i))]);
        send_cmd(1'b0, a, 8'd3);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("wrap_addr", ram_addr, a + 32'(i));
        end
        drain(20);
        check("wrap_done", 32'(done), 32'd1);

        // Single-beat write with wr_valid delayed 5 cycles
        send_cmd(1'b1, 32'h30, 8'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("gap_we_low", 32'(ram_we), 32'd0);
            check("gap_busy", 32'(busy), 32'd1);
        end
        wr_valid = 1'b1; wr_data = 8'h5C;
        wq.push_back('{addr: 32'h30, data: 8'h5C});
        model[8'h30] = 8'h5C;
        tick();
        check("single_we", 32'(ram_we), 32'd1);
        check("single_done", 32'(done), 32'd1);
        wr_valid = 1'b0;
        tick();
        check("single_we_off", 32'(ram_we), 32'd0);
        check("single_done_off", 32'(done), 32'd0);

        // Reset while beat 3 of an 8-beat read is presented
        rq.push_back(model[8'h40]);
        rq.push_back(model[8'h41]);
        send_cmd(1'b0, 32'h40, 8'd7);
        for (int i = 0; i < 5; i++) tick();
        check("mid_rd_valid_pre", 32'(rd_valid), 32'd1);
        d0 = done_seen;
        reset = 1'b0;
        #1;
        check("mid_rd_valid", 32'(rd_valid), 32'd0);
        check("mid_ram_we", 32'(ram_we), 32'd0);
        check("mid_cmd_ready", 32'(cmd_ready), 32'd1);
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_rd_data", 32'(rd_data), 32'd0);
        check("mid_rq_empty", 32'(rq.size()), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("mid_no_done", 32'(done_seen - d0), 32'd0);
        rq.push_back(model[8'h10]);
        rq.push_back(model[8'h11]);
        send_cmd(1'b0, 32'h10, 8'd1);
        drain(20);
        check("post_rst_done", 32'(done), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
